// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master round-robin arbiter with m1 locked bursts and address decode
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   m0_*/m1_* req addr wdata    master request side (byteen nonzero = write)
//   m1_lock                     m1 asks to keep the bus for its next transfer
//   m0_*/m1_* ack rdata err     one-cycle response pulse to the granted master
//   s_valid s_addr s_wdata      registered slave access, one strobe per grant
//   s_byteen s_rdata            slave byte enables / combinational read data
//   busy, owner                 transfer in flight / current or last granted master
module bus_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_byteen,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_byteen,
    input  logic        m1_lock,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic        s_valid,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_byteen,
    input  logic [31:0] s_rdata,
    output logic        busy,
    output logic        owner
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);
    state_t state, next_state;
    logic last_grant, lat_err, lat_wr, win, lock_active, dec_err;
    logic dm_hit, im_hit, tc_hit, word_ok;
    logic [3:0] burst_cnt, burst_next, sel_byteen;
    logic [31:0] sel_addr, sel_wdata, cap_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= next_state;
    end

    always_comb next_state = state == IDLE ? ((m0_req || m1_req) ? ACCESS : IDLE)
                           : state == ACCESS ? RESP : IDLE;

    always_comb begin
        busy = state != IDLE;
        // burst_cnt is nonzero only after a locked m1 grant
        lock_active = burst_cnt != 4'd0 && burst_cnt < MAX_CNT;
        win = (lock_active && m1_req) ? 1'b1 : (m0_req && m1_req) ? !last_grant : m1_req;
        sel_addr = win ? m1_addr : m0_addr;
        sel_wdata = win ? m1_wdata : m0_wdata;
        sel_byteen = win ? m1_byteen : m0_byteen;
        // an exhausted burst that still wins restarts counting at 1
        burst_next = (win && m1_lock) ? ((burst_cnt >= MAX_CNT) ? 4'd1 : burst_cnt + 4'd1) : 4'd0;
        dm_hit = sel_addr <= 32'h0000_2FFF;
        im_hit = sel_addr >= 32'h0000_3000 && sel_addr <= 32'h0000_6FFF;
        tc_hit = (sel_addr >= 32'h0000_7F00 && sel_addr <= 32'h0000_7F0B) ||
                 (sel_addr >= 32'h0000_7F10 && sel_addr <= 32'h0000_7F1B);
        word_ok = (sel_byteen == 4'h0 || sel_byteen == 4'hF) && sel_addr[1:0] == 2'b00;
        dec_err = !(dm_hit || (im_hit && sel_byteen == 4'h0) || (tc_hit && word_ok));
        cap_data = (lat_err || lat_wr) ? 32'h0 : s_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_valid <= 1'b0;
            s_addr <= 32'h0;
            s_wdata <= 32'h0;
            s_byteen <= 4'h0;
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            m0_rdata <= 32'h0;
            m1_rdata <= 32'h0;
            m0_err <= 1'b0;
            m1_err <= 1'b0;
            owner <= 1'b0;
            last_grant <= 1'b1;
            burst_cnt <= 4'd0;
            lat_err <= 1'b0;
            lat_wr <= 1'b0;
        end else begin
            if (state == IDLE && (m0_req || m1_req)) begin
                owner <= win;
                lat_err <= dec_err;
                lat_wr <= |sel_byteen;
                burst_cnt <= burst_next;
                s_valid <= !dec_err;
                s_byteen <= dec_err ? 4'h0 : sel_byteen;
                if (!dec_err) begin
                    s_addr <= sel_addr;
                    s_wdata <= sel_wdata;
                end
            end
            if (state == ACCESS) begin
                s_valid <= 1'b0;
                s_byteen <= 4'h0;
                m0_ack <= !owner;
                m1_ack <= owner;
                if (owner) begin
                    m1_rdata <= cap_data;
                    m1_err <= lat_err;
                end else begin
                    m0_rdata <= cap_data;
                    m0_err <= lat_err;
                end
            end
            if (state == RESP) begin
                m0_ack <= 1'b0;
                m1_ack <= 1'b0;
                last_grant <= owner;
            end
        end
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: random and directed stimulus against a cycle-scheduled transaction model
module tb_bus_arbiter;
    localparam int MAXB = 4;
    localparam int N = 4096;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic m0_req = 1'b0, m1_req = 1'b0, m1_lock = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0, s_rdata = '0;
    logic [3:0] m0_byteen = '0, m1_byteen = '0;
    logic m0_ack, m1_ack, m0_err, m1_err, s_valid, busy, owner;
    logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
    logic [3:0] s_byteen;

    always #5 clk = ~clk;

    bus_arbiter #(.MAX_BURST(MAXB)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_byteen(m0_byteen),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_byteen(m1_byteen),
        .m1_lock(m1_lock),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_byteen(s_byteen),
        .s_rdata(s_rdata), .busy(busy), .owner(owner)
    );

    int checks = 0, errors = 0, cyc = 0, next_arb = 0, lock_run = 0;
    bit last_g = 1'b1, lock_on = 1'b0, exp_own = 1'b0, sv_seen = 1'b0;
    bit e_gnt[N], e_gwho[N], e_sv[N], e_busy[N], e_ack0[N], e_ack1[N], e_er0[N], e_er1[N];
    bit [3:0] e_be[N];
    bit [31:0] e_sa[N], e_sw[N], e_rd0[N], e_rd1[N], rd_val[N];

    function automatic void chk(string nm, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc %0d got %h want %h", nm, cyc, got, exp);
        end
    endfunction

    // Legal: data memory any access, instruction memory reads, timer banks aligned whole words.
    function automatic bit model_err(bit [31:0] a, bit [3:0] be);
        if (a < 32'h3000) return 1'b0;
        if (a < 32'h7000) return be != 4'h0;
        if ((a >= 32'h7F00 && a < 32'h7F0C) || (a >= 32'h7F10 && a < 32'h7F1C))
            return !((be == 4'h0 || be == 4'hF) && a % 4 == 0);
        return 1'b1;
    endfunction

    function automatic bit [31:0] rand_addr();
        case ($urandom_range(6, 0))
            0: return $urandom_range(32'h2FFF, 0);
            1: return $urandom_range(32'h6FFF, 32'h3000);
            2: return 32'h7F00 + 4 * $urandom_range(2, 0);
            3: return 32'h7F10 + 4 * $urandom_range(2, 0);
            4: return 32'h7F00 + $urandom_range(31, 0);
            5: return $urandom_range(32'h7EFF, 32'h7000);
            default: return $urandom;
        endcase
    endfunction

    function automatic bit [3:0] rand_be();
        case ($urandom_range(3, 0))
            0: return 4'h0;
            1: return 4'hF;
            default: return 4'($urandom_range(15, 0));
        endcase
    endfunction

    // Arbitration decision for the current cycle; schedules slave strobe one cycle
    // later and the acknowledge two cycles later, next decision three cycles later.
    task automatic arb();
        bit w, er;
        bit [31:0] a, d;
        bit [3:0] be;
        int c;
        if (!rst_n || cyc < next_arb || !(m0_req || m1_req)) return;
        c = cyc;
        if (m1_req && lock_on && lock_run < MAXB) w = 1'b1;
        else if (m0_req && m1_req) w = !last_g;
        else w = m1_req;
        if (w && m1_lock) begin
            lock_run = (lock_on && lock_run < MAXB) ? lock_run + 1 : 1;
            lock_on = 1'b1;
        end else begin
            lock_run = 0;
            lock_on = 1'b0;
        end
        last_g = w;
        a = w ? m1_addr : m0_addr;
        d = w ? m1_wdata : m0_wdata;
        be = w ? m1_byteen : m0_byteen;
        er = model_err(a, be);
        e_gnt[c+1] = 1'b1;
        e_gwho[c+1] = w;
        e_busy[c+1] = 1'b1;
        e_busy[c+2] = 1'b1;
        if (!er) begin
            e_sv[c+1] = 1'b1;
            e_be[c+1] = be;
            e_sa[c+1] = a;
            e_sw[c+1] = d;
        end
        if (w) begin
            e_ack1[c+2] = 1'b1;
            e_er1[c+2] = er;
            e_rd1[c+2] = (er || be != 4'h0) ? 32'h0 : rd_val[c+1];
        end else begin
            e_ack0[c+2] = 1'b1;
            e_er0[c+2] = er;
            e_rd0[c+2] = (er || be != 4'h0) ? 32'h0 : rd_val[c+1];
        end
        next_arb = c + 3;
    endtask

    task automatic step();
        arb();
        @(posedge clk);
        cyc++;
        #1;
        s_rdata = rd_val[cyc];
        if (e_ack0[cyc-1]) m0_req = 1'b0;
        if (e_ack1[cyc-1]) m1_req = 1'b0;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            sv_seen |= s_valid;
        end
    endtask

    task automatic issue(input bit m, input bit [31:0] a, input bit [31:0] d, input bit [3:0] be, input bit lk);
        if (m) begin
            m1_req = 1'b1; m1_addr = a; m1_wdata = d; m1_byteen = be; m1_lock = lk;
        end else begin
            m0_req = 1'b1; m0_addr = a; m0_wdata = d; m0_byteen = be;
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_immediate", 64'({s_valid, s_byteen, m0_ack, m1_ack, busy}), 64'(0));
        for (int i = cyc; i < cyc + 4 && i < N; i++) begin
            e_gnt[i] = 0; e_sv[i] = 0; e_busy[i] = 0; e_ack0[i] = 0; e_ack1[i] = 0;
            e_be[i] = 0; e_er0[i] = 0; e_er1[i] = 0;
        end
        last_g = 1'b1;
        lock_on = 1'b0;
        lock_run = 0;
        next_arb = cyc + 1;
        step();
        rst_n = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (m0_req || m1_req); i++) step();
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_ctl", 64'({s_valid, s_byteen, m0_ack, m1_ack, m0_err, m1_err, busy, owner}), 64'(0));
            chk("rst_s_bus", {s_addr, s_wdata}, 64'(0));
            chk("rst_rdata", {m0_rdata, m1_rdata}, 64'(0));
            exp_own = 1'b0;
        end else begin
            if (e_gnt[cyc]) exp_own = e_gwho[cyc];
            chk("ctl", 64'({s_valid, s_byteen, m0_ack, m1_ack, busy, owner}),
                64'({e_sv[cyc], e_be[cyc], e_ack0[cyc], e_ack1[cyc], e_busy[cyc], exp_own}));
            if (e_sv[cyc]) chk("s_bus", {s_addr, s_wdata}, {e_sa[cyc], e_sw[cyc]});
            if (e_ack0[cyc]) chk("m0_resp", 64'({m0_err, m0_rdata}), 64'({e_er0[cyc], e_rd0[cyc]}));
            if (e_ack1[cyc]) chk("m1_resp", 64'({m1_err, m1_rdata}), 64'({e_er1[cyc], e_rd1[cyc]}));
        end
    end

    initial begin
        int t;
        for (int i = 0; i < N; i++) rd_val[i] = $urandom;
        repeat (3) step();
        rst_n = 1'b1;
        // lone m0 read
        step();
        issue(0, 32'h10, 32'h0, 4'h0, 0);
        t = cyc;
        rd_val[t+1] = 32'hDEAD_BEEF;
        step();
        chk("rd_svalid", 64'({s_valid, s_byteen, s_addr}), 64'({1'b1, 4'h0, 32'h10}));
        step();
        chk("rd_ack", 64'({m0_ack, m0_err, m0_rdata}), 64'({1'b1, 1'b0, 32'hDEAD_BEEF}));
        step();
        // simultaneous requests from reset alternate starting with m0
        pulse_reset();
        issue(0, 32'h40, 32'h0, 4'h0, 0);
        issue(1, 32'h44, 32'h0, 4'h0, 0);
        for (int i = 1; i <= 11; i++) begin
            step();
            if (!m0_req) issue(0, 32'h40, 32'h0, 4'h0, 0);
            if (!m1_req) issue(1, 32'h44, 32'h0, 4'h0, 0);
            if (i % 3 == 2) chk("rr_order", 64'({m0_ack, m1_ack}), ((i / 3) % 2 == 0) ? 64'(2'b10) : 64'(2'b01));
        end
        drain();
        // locked m1 burst against a waiting m0
        pulse_reset();
        issue(1, 32'h100, 32'h0, 4'h0, 1);
        for (int i = 1; i <= 17; i++) begin
            step();
            if (i <= 15 && !m0_req) issue(0, 32'h200, 32'h0, 4'h0, 0);
            if (i <= 15 && !m1_req) issue(1, 32'h104, 32'h0, 4'h0, 1);
            if (i % 3 == 2) chk("burst_ack", 64'({m0_ack, m1_ack}), (i == 14) ? 64'(2'b10) : 64'(2'b01));
        end
        drain();
        // rejected accesses never reach the slave
        sv_seen = 1'b0;
        issue(1, 32'h3004, 32'hAAAA, 4'hF, 0);
        steps(2);
        chk("im_write", 64'({m1_ack, m1_err}), 64'(2'b11));
        steps(1);
        issue(0, 32'h7F04, 32'h55, 4'h3, 0);
        steps(2);
        chk("tc_partial", 64'({m0_ack, m0_err}), 64'(2'b11));
        steps(1);
        issue(0, 32'h8000, 32'h0, 4'h0, 0);
        steps(2);
        chk("unmapped", 64'({m0_ack, m0_err}), 64'(2'b11));
        chk("err_no_svalid", 64'(sv_seen), 64'(0));
        steps(1);
        // full-word timer write
        issue(0, 32'h7F14, 32'h1234, 4'hF, 0);
        step();
        chk("tc1_write", 64'({s_valid, s_byteen, s_wdata}), 64'({1'b1, 4'hF, 32'h1234}));
        step();
        chk("tc1_ack", 64'({m0_ack, m0_err}), 64'(2'b10));
        step();
        // reset during ACCESS discards the transfer, request then retried
        issue(0, 32'h20, 32'h0, 4'h0, 0);
        step();
        chk("pre_rst_svalid", 64'(s_valid), 64'(1));
        pulse_reset();
        chk("no_ack_after_rst", 64'({m0_ack, m1_ack, busy}), 64'(0));
        rd_val[cyc+1] = 32'hCAFE_F00D;
        step();
        chk("retry_svalid", 64'({s_valid, m0_ack}), 64'(2'b10));
        step();
        chk("retry_ack", 64'({m0_ack, m0_rdata}), 64'({1'b1, 32'hCAFE_F00D}));
        step();
        // random traffic
        while (cyc < 2600) begin
            step();
            if (!m0_req && $urandom_range(1, 0) == 1) issue(0, rand_addr(), $urandom, rand_be(), 0);
            if (!m1_req && $urandom_range(3, 0) != 0) issue(1, rand_addr(), $urandom, rand_be(), 1'($urandom_range(1, 0)));
            if ($urandom_range(299, 0) == 0) pulse_reset();
        end
        drain();
        steps(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
